// File: rtl/mem_stage.sv
// MINAv2 MEM stage: word load/store over a req/ack data bus, MEM/WB pipeline register,
// upstream stall while a transaction is outstanding, bus timeout and misalignment faults.
module mem_stage #(
  parameter int BUS_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [70:0] in_params,   // {rd_addr[4:0], rd_data[31:0], mem_op[1:0], mem_data[31:0]}
  output logic        stall,
  output logic        out_valid,
  output logic [36:0] out_params,  // {rd_addr[4:0], rd_data[31:0]}
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        misalign_fault,
  output logic        bus_fault
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [4:0]        in_rd_addr;
  logic [31:0]       in_rd_data;
  logic [1:0]        in_mem_op;
  logic [31:0]       in_mem_data;
  logic              is_mem, aligned, tmo_hit;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [4:0]        rd_addr_p1;
  logic              vld_p1;
  logic [36:0]       wb_p1;

  assign in_rd_addr  = in_params[70:66];
  assign in_rd_data  = in_params[65:34];
  assign in_mem_op   = in_params[33:32];
  assign in_mem_data = in_params[31:0];

  // Reserved op 2'b11 falls through as a plain ALU passthrough.
  assign is_mem  = (in_mem_op == OP_LOAD) || (in_mem_op == OP_STORE);
  assign aligned = (in_rd_data[1:0] == 2'b00);
  assign tmo_hit = (BUS_TIMEOUT != 0) && (tmo_cnt == TMO_W'(BUS_TIMEOUT - 1)) && !dbus_ack;

  assign out_valid  = vld_p1;
  assign out_params = wb_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_mem && aligned) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dbus_ack || tmo_hit) state_nxt = IDLE;
        else                     stall     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Upstream must not see a stall while the stage is held in reset.
    if (rst) stall = 1'b0;
  end

  // p1: MEM/WB register and the bus request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      wb_p1          <= '0;
      rd_addr_p1     <= '0;
      dbus_req       <= 1'b0;
      dbus_we        <= 1'b0;
      dbus_addr      <= '0;
      dbus_wdata     <= '0;
      dbus_wstb      <= '0;
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_valid) begin
            vld_p1 <= 1'b0;
          end else if (!is_mem) begin
            vld_p1 <= 1'b1;
            wb_p1  <= {in_rd_addr, in_rd_data};
          end else if (!aligned) begin
            vld_p1         <= 1'b1;
            wb_p1          <= '0;
            misalign_fault <= 1'b1;
          end else begin
            vld_p1     <= 1'b0;
            rd_addr_p1 <= in_rd_addr;
            tmo_cnt    <= '0;
            dbus_req   <= 1'b1;
            dbus_addr  <= in_rd_data;
            dbus_we    <= (in_mem_op == OP_STORE);
            dbus_wdata <= (in_mem_op == OP_STORE) ? in_mem_data : 32'h0;
            dbus_wstb  <= (in_mem_op == OP_STORE) ? 4'b1111 : 4'b0000;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            vld_p1   <= 1'b1;
            wb_p1    <= dbus_we ? 37'h0 : {rd_addr_p1, dbus_rdata};
            dbus_req <= 1'b0;
          end else if (tmo_hit) begin
            vld_p1    <= 1'b1;
            wb_p1     <= '0;
            dbus_req  <= 1'b0;
            bus_fault <= 1'b1;
          end else begin
            vld_p1  <= 1'b0;
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: vld_p1 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random instruction stream with a transaction-level expectation model,
// directed cases with literal expectations, and a mid-transaction asynchronous reset.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [70:0] in_params = '0;
  logic        stall, out_valid, dbus_req, dbus_we, misalign_fault, bus_fault;
  logic [36:0] out_params;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstb;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;

  mem_stage #(.BUS_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_params(in_params),
    .stall(stall), .out_valid(out_valid), .out_params(out_params),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstb(dbus_wstb), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .misalign_fault(misalign_fault), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Expected outputs, updated by the driver right after each active edge.
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_mis = 1'b0, exp_bf = 1'b0;
  logic        exp_req = 1'b0, exp_we = 1'b0;
  logic [36:0] exp_out = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstb = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      if (exp_valid) chk("out_params", 64'(out_params), 64'(exp_out));
      chk("misalign_fault", 64'(misalign_fault), 64'(exp_mis));
      chk("bus_fault", 64'(bus_fault), 64'(exp_bf));
      chk("dbus_req", 64'(dbus_req), 64'(exp_req));
      if (exp_req) begin
        chk("dbus_we", 64'(dbus_we), 64'(exp_we));
        chk("dbus_addr", 64'(dbus_addr), 64'(exp_addr));
        chk("dbus_wdata", 64'(dbus_wdata), 64'(exp_wdata));
        chk("dbus_wstb", 64'(dbus_wstb), 64'(exp_wstb));
      end
    end
  end

  // One instruction from the upstream point of view. delay = BUSY cycles without ack
  // before the bus answers; delay >= TMO means the bus never answers in time.
  task automatic run_instr(input logic v, input logic [4:0] rd, input logic [31:0] data,
                           input logic [1:0] op, input logic [31:0] md, input int delay,
                           input logic [31:0] rdata, output int n_stall, output int n_req);
    logic is_mem, mis, ack, tmo;
    n_stall = 0;
    n_req = 0;
    in_valid = v;
    in_params = {rd, data, op, md};
    dbus_ack = 1'($urandom_range(0, 1));
    dbus_rdata = $urandom;
    is_mem = v && (op == 2'b01 || op == 2'b10);
    mis = is_mem && (data[1:0] != 2'b00);
    exp_stall = is_mem && !mis;
    #1;
    if (stall === 1'b1) n_stall++;
    if (dbus_req === 1'b1) n_req++;
    @(posedge clk); #1;
    exp_mis = 1'b0;
    exp_bf = 1'b0;
    if (!v) begin
      exp_valid = 1'b0;
    end else if (!is_mem) begin
      exp_valid = 1'b1;
      exp_out = {rd, data};
    end else if (mis) begin
      exp_valid = 1'b1;
      exp_out = '0;
      exp_mis = 1'b1;
    end else begin
      exp_valid = 1'b0;
      exp_req = 1'b1;
      exp_addr = data;
      exp_we = (op == 2'b10);
      exp_wdata = exp_we ? md : 32'h0;
      exp_wstb = exp_we ? 4'hF : 4'h0;
      for (int k = 1; k <= TMO; k++) begin
        ack = (k == delay + 1);
        tmo = (k == TMO) && !ack;
        dbus_ack = ack;
        dbus_rdata = ack ? rdata : $urandom;
        exp_stall = !(ack || tmo);
        #1;
        if (stall === 1'b1) n_stall++;
        if (dbus_req === 1'b1) n_req++;
        @(posedge clk); #1;
        if (ack || tmo) begin
          exp_req = 1'b0;
          exp_valid = 1'b1;
          exp_bf = tmo;
          exp_out = (ack && !exp_we) ? {rd, rdata} : 37'h0;
          break;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nr, sel, dly;
    logic [1:0]  op;
    logic [31:0] d;

    #2;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_params", 64'(out_params), 64'(0));
    chk("rst_dbus_req", 64'(dbus_req), 64'(0));
    chk("rst_dbus_we", 64'(dbus_we), 64'(0));
    chk("rst_dbus_addr", 64'(dbus_addr), 64'(0));
    chk("rst_dbus_wdata", 64'(dbus_wdata), 64'(0));
    chk("rst_dbus_wstb", 64'(dbus_wstb), 64'(0));
    chk("rst_misalign", 64'(misalign_fault), 64'(0));
    chk("rst_bus_fault", 64'(bus_fault), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU passthrough
    run_instr(1'b1, 5'd5, 32'h1234, 2'b00, 32'h0, 0, 32'h0, ns, nr);
    chk("alu_out", 64'(out_params), 64'({5'd5, 32'h1234}));
    chk("alu_valid", 64'(out_valid), 64'(1));
    chk("alu_nreq", 64'(nr), 64'(0));

    // Load answered after 3 silent BUSY cycles
    run_instr(1'b1, 5'd7, 32'h100, 2'b01, 32'h55, 3, 32'hDEADBEEF, ns, nr);
    chk("load_out", 64'(out_params), 64'({5'd7, 32'hDEADBEEF}));
    chk("load_nstall", 64'(ns), 64'(4));
    chk("load_nreq", 64'(nr), 64'(4));
    chk("load_no_fault", 64'(bus_fault), 64'(0));

    // Store with same-cycle ack
    run_instr(1'b1, 5'd9, 32'h200, 2'b10, 32'hCAFEF00D, 0, 32'h0, ns, nr);
    chk("store_out", 64'(out_params), 64'(0));
    chk("store_nstall", 64'(ns), 64'(1));

    // Misaligned load
    run_instr(1'b1, 5'd3, 32'h103, 2'b01, 32'h0, 0, 32'h0, ns, nr);
    chk("mis_pulse", 64'(misalign_fault), 64'(1));
    chk("mis_out", 64'(out_params), 64'(0));
    chk("mis_nreq", 64'(nr), 64'(0));

    // Timeout
    run_instr(1'b1, 5'd4, 32'h400, 2'b01, 32'h0, 99, 32'h0, ns, nr);
    chk("tmo_pulse", 64'(bus_fault), 64'(1));
    chk("tmo_nreq", 64'(nr), 64'(4));
    chk("tmo_out", 64'(out_params), 64'(0));

    // Reserved op behaves as passthrough
    run_instr(1'b1, 5'd12, 32'h0BAD_0001, 2'b11, 32'h0, 0, 32'h0, ns, nr);
    chk("rsv_out", 64'(out_params), 64'({5'd12, 32'h0BAD_0001}));

    // Random stream
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 3) ? 2'b00 : (sel == 3) ? 2'b11 : (sel < 7) ? 2'b01 : 2'b10;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
      dly = $urandom_range(0, TMO + 1);
      run_instr(1'($urandom_range(0, 7) != 0), 5'($urandom), d, op, $urandom, dly, $urandom, ns, nr);
    end

    // Reset in the middle of a load
    run_instr(1'b0, 5'd0, 32'h0, 2'b00, 32'h0, 0, 32'h0, ns, nr);
    chk_en = 1'b0;
    in_valid = 1'b1;
    in_params = {5'd9, 32'h300, 2'b01, 32'h0};
    dbus_ack = 1'b0;
    @(posedge clk); #1;
    chk("busy_req", 64'(dbus_req), 64'(1));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_req", 64'(dbus_req), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_stall", 64'(stall), 64'(0));
    chk("arst_addr", 64'(dbus_addr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    dbus_ack = 1'b1;
    dbus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    chk("late_ack_valid", 64'(out_valid), 64'(0));
    chk("late_ack_req", 64'(dbus_req), 64'(0));
    dbus_ack = 1'b0;
    exp_valid = 1'b0;
    exp_req = 1'b0;
    exp_mis = 1'b0;
    exp_bf = 1'b0;
    exp_stall = 1'b0;
    chk_en = 1'b1;
    run_instr(1'b1, 5'd3, 32'hABCD, 2'b00, 32'h0, 0, 32'h0, ns, nr);
    chk("post_rst_alu", 64'(out_params), 64'({5'd3, 32'hABCD}));
    run_instr(1'b0, 5'd0, 32'h0, 2'b00, 32'h0, 0, 32'h0, ns, nr);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the MINAv2 five-stage pipeline.
- Consumes the EX/MEM payload (mem_params_t) and performs word loads and stores on a req/ack data bus.
- Holds the MEM/WB pipeline register and produces the wb_params_t payload consumed by writeback.
- Stalls upstream stages while a bus transaction is outstanding.

Parameters:
- BUS_TIMEOUT, 16, maximum BUSY cycles to wait for dbus_ack before aborting; 0 disables the timeout.
- TMO_W, 8, width of the timeout counter; BUS_TIMEOUT must be < 2**TMO_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_params holds a valid instruction.
- in_params  in  mem_params_t  rd_addr, rd_data (ALU result / effective address), mem_op, mem_data (store data).
- stall  out  1  upstream must hold in_params/in_valid stable this cycle.
- out_valid  out  1  out_params valid for writeback.
- out_params  out  wb_params_t  rd_addr, rd_data to the register file.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = store, 0 = load.
- dbus_addr  out  32  word address; bits [1:0] are always 0.
- dbus_wdata  out  32  store data.
- dbus_wstb  out  wrstb_t  byte strobes: 4'b1111 for stores, 4'b0000 for loads.
- dbus_ack  in  1  transaction complete this cycle.
- dbus_rdata  in  32  load data; valid when dbus_ack=1.
- misalign_fault  out  1  one-cycle pulse: a load/store address had [1:0] != 0.
- bus_fault  out  1  one-cycle pulse: the bus timeout expired.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; out_valid=0; out_params=0; dbus_req=0; dbus_we=0; dbus_addr=0; dbus_wdata=0; dbus_wstb=0; both fault outputs=0; timeout counter=0. Reset mid-transaction drops dbus_req immediately. A late dbus_ack after reset is ignored.
- rd_addr = 0 means "no writeback". Stores and faulted operations emit out_valid=1 with rd_addr=0 and rd_data=0 so writeback retires them.
- State IDLE:
  - in_valid=0: out_valid<=0 at the next edge.
  - in_valid=1, mem_op=NONE: out_params<={rd_addr, rd_data} and out_valid<=1 at the next edge. stall=0. Latency is 1 cycle.
  - in_valid=1, mem_op=LOAD/STORE, rd_data[1:0]!=0: no bus access. stall=0. At the next edge out_valid<=1 with rd_addr=0, and misalign_fault pulses for 1 cycle.
  - in_valid=1, mem_op=LOAD/STORE, aligned: stall=1 combinationally. At the next edge: dbus_req<=1; dbus_addr<=rd_data; dbus_we<=(STORE); dbus_wdata<=mem_data (0 for loads); dbus_wstb<=per the mem_op rule above; latch rd_addr; counter<=0; out_valid<=0; state<=BUSY.
  - mem_op=2'b11 (reserved) is treated as NONE.
- State BUSY:
  - Bus outputs are held stable until ack or abort.
  - dbus_ack=0: stall=1; out_valid<=0; counter increments.
  - dbus_ack=1: stall=0 in the same cycle, so upstream advances at this edge. At the edge: load gives out_params<={latched rd_addr, dbus_rdata}; store gives out_params<={0,0}; out_valid<=1; dbus_req<=0; state<=IDLE. in_params is ignored in this cycle.
  - Timeout: when BUS_TIMEOUT!=0 and counter==BUS_TIMEOUT-1 with dbus_ack=0, stall=0. At the edge: dbus_req<=0; out_valid<=1 with rd_addr=0; bus_fault pulses 1 cycle; state<=IDLE.
  - If ack and the timeout coincide in the same cycle, ack wins and there is no fault.
- dbus_ack in IDLE is ignored.
- Minimum memory-op latency is 2 cycles (accept edge, then the ack edge). Back-to-back memory ops have one IDLE accept cycle between transactions.
- out_valid and the fault pulses are registered. stall is combinational from state, in_valid, in_params, dbus_ack and the counter.

Test Plan:
- ALU passthrough: in_valid=1, mem_op=NONE, rd_addr=5, rd_data=0x1234 -> next cycle out_valid=1, out_params={5,0x1234}, stall=0, dbus_req never asserted.
- Load, ack after 3 BUSY cycles: rd_addr=7, addr=0x100, rdata=0xDEADBEEF -> dbus_req=1, we=0, wstb=0 for 3 cycles; stall=1 until the ack cycle; then out_params={7,0xDEADBEEF}, out_valid=1; upstream held stable throughout.
- Store with same-cycle ack: addr=0x200, mem_data=0xCAFEF00D -> dbus_we=1, wstb=4'b1111, wdata=0xCAFEF00D; next edge out_valid=1, rd_addr=0; stall high for exactly 1 cycle.
- Misaligned load addr=0x103 -> no dbus_req; misalign_fault pulses 1 cycle; out_valid=1, rd_addr=0.
- Timeout: BUS_TIMEOUT=4, ack held 0 -> dbus_req high for exactly 4 cycles; bus_fault pulses 1 cycle; out_valid=1, rd_addr=0. Ack arriving on the 4th cycle instead -> normal completion, no fault.
- Reset asserted mid-BUSY -> dbus_req, out_valid and stall drop asynchronously; an ack arriving after release is ignored; the next ALU op completes normally.
